// File: rtl/fp_muldiv_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_muldiv_seq_if                                                   |
// | Start/done handshake bundle for the sequential FP multiply/divide. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fp_muldiv_seq_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    logic                   start;
    logic                   op;
    logic [EXP_W+MAN_W:0]   a;
    logic [EXP_W+MAN_W:0]   b;
    logic                   busy;
    logic                   done;
    logic [EXP_W+MAN_W:0]   result;
    logic [1:0]             ofuf;

    modport master (output start, op, a, b, input busy, done, result, ofuf);
    modport slave  (input start, op, a, b, output busy, done, result, ofuf);
endinterface
`default_nettype wire

// File: rtl/fp_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_muldiv_seq                                                      |
// | Sequential FP multiply (shift-add) / divide (restoring) unit.      |
// | Define FPMD_RNE_EN for round-to-nearest-even, else truncation.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fp_muldiv_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    fp_muldiv_seq_if.slave bus
);
    localparam int c_w  = 1 + EXP_W + MAN_W;
    localparam int c_mw = MAN_W + 1;
    localparam int c_pw = 2 * c_mw;
    localparam int c_qw = MAN_W + 3;
    localparam int c_rw = MAN_W + 3;
    localparam int c_xw = EXP_W + 2;
    localparam int c_cw = $clog2(c_qw + 1);
    localparam logic [c_xw-1:0] c_bias = c_xw'((1 << (EXP_W - 1)) - 1);
    localparam logic [c_xw-1:0] c_emax = c_xw'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SPECIAL = 3'd1,
        S_ITER    = 3'd2,
        S_NORM    = 3'd3,
        S_ROUND   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                op_q, op_d;
    logic [c_w-1:0]      a_q, a_d, b_q, b_d;
    logic [c_pw-1:0]     prod_q, prod_d;
    logic [c_rw-1:0]     rem_q, rem_d;
    logic [c_qw-1:0]     quo_q, quo_d;
    logic [c_cw-1:0]     cnt_q, cnt_d;
    logic [c_xw-1:0]     exp_q, exp_d;
    logic [MAN_W-1:0]    man_q, man_d;
    logic                g_q, g_d, s_q, s_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [c_w-1:0]      result_q, result_d;
    logic [1:0]          ofuf_q, ofuf_d;

    logic                w_sign;
    logic [EXP_W-1:0]    w_ea, w_eb;
    logic [c_xw-1:0]     w_ea_x, w_eb_x;
    logic [c_mw-1:0]     w_ma, w_mb;
    logic [c_mw:0]       w_sum;
    logic                w_ge;
    logic [c_rw-1:0]     w_rnext;
    logic                w_inc, w_carry;
    logic [MAN_W-1:0]    w_man_r;
    logic [c_xw-1:0]     w_exp_r;

    assign w_sign  = a_q[c_w-1] ^ b_q[c_w-1];
    assign w_ea    = a_q[c_w-2:MAN_W];
    assign w_eb    = b_q[c_w-2:MAN_W];
    assign w_ea_x  = {2'b00, w_ea};
    assign w_eb_x  = {2'b00, w_eb};
    assign w_ma    = {1'b1, a_q[MAN_W-1:0]};
    assign w_mb    = {1'b1, b_q[MAN_W-1:0]};

    // One multiplier bit per step: conditional add into the upper half, then shift right.
    assign w_sum   = {1'b0, prod_q[c_pw-1:c_mw]} + (prod_q[0] ? {1'b0, w_ma} : '0);
    assign w_ge    = (rem_q >= {{(c_rw-c_mw){1'b0}}, w_mb});
    assign w_rnext = w_ge ? (rem_q - {{(c_rw-c_mw){1'b0}}, w_mb}) : rem_q;

`ifdef FPMD_RNE_EN
    assign w_inc = g_q & (s_q | man_q[0]);
`else
    assign w_inc = 1'b0;
`endif
    assign {w_carry, w_man_r} = {1'b0, man_q} + {{MAN_W{1'b0}}, w_inc};
    assign w_exp_r = exp_q + {{(c_xw-1){1'b0}}, w_carry};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        man_d    = man_q;
        g_d      = g_q;
        s_d      = s_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        ofuf_d   = ofuf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    busy_d  = 1'b1;
                    state_d = S_SPECIAL;
                end
            end
            S_SPECIAL: begin
                if (w_ea == '0 || w_eb == '0) begin
                    if (w_ea != '0 && op_q) begin
                        result_d = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        ofuf_d   = 2'b10;
                    end else begin
                        result_d = {w_sign, {(c_w-1){1'b0}}};
                        ofuf_d   = 2'b00;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    exp_d   = op_q ? (w_ea_x - w_eb_x + c_bias) : (w_ea_x + w_eb_x - c_bias);
                    prod_d  = {{c_mw{1'b0}}, w_mb};
                    rem_d   = {{(c_rw-c_mw){1'b0}}, w_ma};
                    quo_d   = '0;
                    cnt_d   = op_q ? c_cw'(c_qw) : c_cw'(c_mw);
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (op_q) begin
                    quo_d = {quo_q[c_qw-2:0], w_ge};
                    rem_d = {w_rnext[c_rw-2:0], 1'b0};
                end else begin
                    prod_d = {w_sum, prod_q[c_mw-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == c_cw'(1)) state_d = S_NORM;
            end
            S_NORM: begin
                if (op_q) begin
                    if (quo_q[c_qw-1]) begin
                        man_d = quo_q[c_qw-2 -: MAN_W];
                        g_d   = quo_q[1];
                        s_d   = quo_q[0] | (rem_q != '0);
                    end else begin
                        man_d = quo_q[c_qw-3 -: MAN_W];
                        g_d   = quo_q[0];
                        s_d   = (rem_q != '0);
                        exp_d = exp_q - 1'b1;
                    end
                end else begin
                    if (prod_q[c_pw-1]) begin
                        man_d = prod_q[c_pw-2 -: MAN_W];
                        g_d   = prod_q[c_mw-1];
                        s_d   = |prod_q[c_mw-2:0];
                        exp_d = exp_q + 1'b1;
                    end else begin
                        man_d = prod_q[c_pw-3 -: MAN_W];
                        g_d   = prod_q[c_mw-2];
                        s_d   = |prod_q[c_mw-3:0];
                    end
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (!w_exp_r[c_xw-1] && (w_exp_r >= c_emax)) begin
                    result_d = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ofuf_d   = 2'b10;
                end else if (w_exp_r[c_xw-1] || (w_exp_r == '0)) begin
                    result_d = {w_sign, {(c_w-1){1'b0}}};
                    ofuf_d   = 2'b01;
                end else begin
                    result_d = {w_sign, w_exp_r[EXP_W-1:0], w_man_r};
                    ofuf_d   = 2'b00;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            man_q    <= '0;
            g_q      <= 1'b0;
            s_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ofuf_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            exp_q    <= exp_d;
            man_q    <= man_d;
            g_q      <= g_d;
            s_q      <= s_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            ofuf_q   <= ofuf_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ofuf   = ofuf_q;
endmodule
`default_nettype wire

// File: tb/tb_fp_muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fp_muldiv_seq                                                   |
// | Scoreboard bench: directed vectors for fp_muldiv_seq.              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fp_muldiv_seq;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    fp_muldiv_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
    fp_muldiv_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [1:0]  ofuf;
        logic [31:0] lat;
        logic [31:0] t0;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    logic [31:0] cyc = '0;

`ifdef FPMD_RNE_EN
    localparam logic [15:0] c_rnd_exp = 16'h4082;
`else
    localparam logic [15:0] c_rnd_exp = 16'h4081;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (!reset_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no operation pending at t=%0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", {16'h0, bus.result}, {16'h0, mon_e.res});
                    chk("ofuf", {30'h0, bus.ofuf}, {30'h0, mon_e.ofuf});
                    chk("latency", cyc - mon_e.t0, mon_e.lat);
                    chk("busy_cycles", busy_cnt, mon_e.lat);
                    chk("busy_low_at_done", {31'h0, bus.busy}, 32'h0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic o, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic [1:0] eo, input int l, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", n);
        end
        bus.op    = o;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.res  = er;
            e.ofuf = eo;
            e.lat  = l;
            e.t0   = cyc;
            sb.push_back(e);
        end
        bus.start = 1'b0;
        bus.a     = 16'hFFFF;
        bus.b     = 16'hFFFF;
        bus.op    = ~o;
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'h0, bus.busy}, 32'h0);
        chk("reset_done", {31'h0, bus.done}, 32'h0);
        chk("reset_result", {16'h0, bus.result}, 32'h0);
        chk("reset_ofuf", {30'h0, bus.ofuf}, 32'h0);
        reset_n = 1'b1;

        issue(1'b0, 16'h4000, 16'h4200, 16'h4600, 2'b00, 14, 1'b1);
        issue(1'b0, 16'hC000, 16'h4200, 16'hC600, 2'b00, 14, 1'b1);
        issue(1'b0, 16'h3E01, 16'h3E01, c_rnd_exp, 2'b00, 14, 1'b1);
        issue(1'b1, 16'h3C00, 16'h4200, 16'h3555, 2'b00, 16, 1'b1);
        issue(1'b1, 16'hC000, 16'h4000, 16'hBC00, 2'b00, 16, 1'b1);
        issue(1'b1, 16'h4000, 16'h0000, 16'h7C00, 2'b10, 1, 1'b1);
        issue(1'b0, 16'h0000, 16'h4200, 16'h0000, 2'b00, 1, 1'b1);
        issue(1'b0, 16'h4200, 16'h8000, 16'h8000, 2'b00, 1, 1'b1);
        issue(1'b0, 16'h7800, 16'h4000, 16'h7C00, 2'b10, 14, 1'b1);
        issue(1'b0, 16'h0400, 16'h0400, 16'h0000, 2'b01, 14, 1'b1);

        // start while busy must be ignored
        issue(1'b0, 16'h4000, 16'h4200, 16'h4600, 2'b00, 14, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 1'b1;
        bus.a     = 16'h3C00;
        bus.b     = 16'h4200;
        @(posedge clk);
        #1;
        bus.start = 1'b0;

        // reset in flight at E0+5
        issue(1'b0, 16'h4000, 16'h4400, 16'h0000, 2'b00, 14, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_busy", {31'h0, bus.busy}, 32'h0);
        chk("midreset_done", {31'h0, bus.done}, 32'h0);
        chk("midreset_result", {16'h0, bus.result}, 32'h0);
        chk("midreset_ofuf", {30'h0, bus.ofuf}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_busy", {31'h0, bus.busy}, 32'h0);

        issue(1'b1, 16'h3C00, 16'h4200, 16'h3555, 2'b00, 16, 1'b1);
        issue(1'b1, 16'h3C00, 16'h3C00, 16'h3C00, 2'b00, 16, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d operations never completed", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/fp_muldiv_seq.md
# fp_muldiv_seq

Parametrised sequential floating-point multiply/divide unit for a configurable IEEE-style format: 1 sign bit, `EXP_W` exponent bits, `MAN_W` stored mantissa bits, hidden leading 1. It is the next-generation multiply/divide stage of the FPU datapath:

- start/done handshake;
- bit-serial shift-add multiplier and restoring divider;
- single-step normalisation;
- optional round-to-nearest-even;
- saturating overflow/underflow flags.

## Interface

**Parameters**

- `EXP_W`, 5: exponent width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, 10: stored mantissa width (hidden bit excluded).

**Ports**

- `clk`, in, 1: rising-edge clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: accept operands; sampled only in IDLE.
- `op`, in, 1: operation select, 0 = multiply (a*b), 1 = divide (a/b).
- `a`, `b`, in, 1+EXP_W+MAN_W: operands.
- `busy`, out, 1: high from the accept edge until the edge that raises `done`.
- `done`, out, 1: single-cycle pulse; `result` and `ofuf` are valid from this cycle onward.
- `result`, out, 1+EXP_W+MAN_W: packed result; held until the next `done`.
- `ofuf`, out, 2: status flags; 2'b10 = overflow or divide-by-zero, 2'b01 = underflow, 2'b00 = ok; held like `result`.

## Operation

**Reset**

- All outputs = 0, FSM = IDLE.
- Applies at any time, including mid-operation; the in-flight operation is discarded with no `done`.

**Operand capture**

- On the accept edge, `a`, `b` and `op` are registered.
- Later input changes have no effect on the operation in progress.
- `start` while busy is ignored.

**Input classification**

- An operand with exponent field 0 is zero. Subnormals are flushed; the mantissa is ignored.
- Exponent all-ones is treated as an ordinary finite value (no inf/NaN decoding).

**FSM: IDLE → SPECIAL → ITER → NORM → ROUND → IDLE**

- **SPECIAL**
  - a zero: result = {sign, 0}, ofuf = 00.
  - b zero, multiply: result = {sign, 0}, ofuf = 00.
  - b zero, divide: result = {sign, all-ones exponent, 0 mantissa}, ofuf = 10.
  - For each of these cases: `done`, then IDLE. Otherwise go to ITER.
  - Result sign = sign_a XOR sign_b in every case.
- **ITER**
  - Multiply: MAN_W+1 shift-add steps over the 2*(MAN_W+1)-bit product, which lies in [1,4).
  - Divide: MAN_W+3 restoring steps, one quotient bit per cycle, for a quotient in (0.5,2).
  - Exponent is computed in a signed EXP_W+2-bit register: ea+eb-bias for multiply, ea-eb+bias for divide.
- **NORM**
  - Multiply: if the product is ≥2, shift right 1 and increment the exponent.
  - Divide: if the quotient is <1, shift left 1 and decrement the exponent.
  - Extract MAN_W mantissa bits, guard bit G, and sticky bit S (OR of the remaining product bits, or the nonzero-remainder flag for divide).
- **ROUND**
  - Apply rounding (see Configuration).
  - A mantissa carry-out sets mantissa = 0 and increments the exponent.
  - Then check the final exponent e:
    - e ≥ 2^EXP_W-1: result = {sign, all-ones, 0}, ofuf = 10.
    - e ≤ 0: result = {sign, 0}, ofuf = 01.
    - Otherwise: packed result, ofuf = 00.
  - Raise `done`, go to IDLE.

## Timing

- Latency L is measured from the accept edge E0 to the edge that raises `done`:
  - special case: L = 1;
  - multiply: L = MAN_W+4 (14 at default);
  - divide: L = MAN_W+6 (16 at default).
- Latency is fixed per op and independent of operand values.
- `busy` drops on the same edge that raises `done`.
- `done` is high for exactly one cycle.
- `start` high in the `done` cycle is accepted, giving back-to-back operation with one IDLE cycle.
- Throughput: one operation per L+1 cycles.

## Configuration

- **`FPMD_RNE_EN` defined:** round to nearest, ties to even.
  - Increment when G & (S | lsb).
  - The divider computes one extra quotient bit to form G.
- **`FPMD_RNE_EN` undefined:** truncation; G and S are discarded.
  - ROUND still occupies its cycle, so latency is unchanged.
  - Overflow/underflow checks are identical.

## Test plan

All cases use default parameters.

- **Basic multiply:** op = 0, a = 0x4000, b = 0x4200 → done at E0+14, result = 0x4600, ofuf = 00, busy high for 14 cycles. Repeat with a = 0xC000 → 0xC600.
- **Rounding:** op = 0, a = b = 0x3E01 → result = 0x4082 with `FPMD_RNE_EN`, 0x4081 without.
- **Divide:** op = 1, a = 0x3C00, b = 0x4200 → done at E0+16, result = 0x3555, ofuf = 00.
- **Special cases:**
  - op = 1, a = 0x4000, b = 0x0000 → done at E0+1, result = 0x7C00, ofuf = 10.
  - op = 0, a = 0x0000, b = 0x4200 → result = 0x0000, ofuf = 00.
- **Overflow/underflow:**
  - op = 0, a = 0x7800, b = 0x4000 → result = 0x7C00, ofuf = 10.
  - op = 0, a = b = 0x0400 → result = 0x0000, ofuf = 01.
- **Handshake and reset:**
  - Pulse `start` while busy with different operands → ignored; original result returned.
  - Assert `reset_n` low at E0+5 → outputs 0, no `done`.
  - After release, a new start completes normally.
